// File: rtl/dcache_pkg.sv
// Shared data-cache types: write-buffer entry layout and drain engine states.
package dcache_pkg;

  localparam int DCACHE_DATA_W = 32;
  localparam int DCACHE_ADDR_W = 30;
  localparam int DCACHE_SEL_W  = DCACHE_DATA_W / 8;

  // Entry as stored in the write-buffer FIFO, packed {data, sel, address} MSB to LSB.
  typedef struct packed {
    logic [DCACHE_DATA_W-1:0] data;
    logic [DCACHE_SEL_W-1:0]  sel;
    logic [DCACHE_ADDR_W-1:0] address;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    REQ   = 2'd2,
    WAIT  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/wbuf_drain.sv
// Write-buffer drain engine: pops one store at a time and issues it as a single
// Wishbone pipelined write, yielding to the refill path via hold_i.
module wbuf_drain
  import dcache_pkg::*;
#(
  parameter  int DATA_W  = DCACHE_DATA_W,
  parameter  int ADDR_W  = DCACHE_ADDR_W,
  localparam int SEL_W   = DATA_W / 8,
  localparam int ENTRY_W = DATA_W + SEL_W + ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               fifo_empty_i,
  output logic               fifo_re_o,
  input  logic [ENTRY_W-1:0] fifo_rdata_i,
  input  logic               hold_i,
  output logic               cyc_o,
  output logic               stb_o,
  output logic               we_o,
  output logic [ADDR_W-1:0]  adr_o,
  output logic [DATA_W-1:0]  dat_o,
  output logic [SEL_W-1:0]   sel_o,
  input  logic               stall_i,
  input  logic               ack_i,
  input  logic               err_i,
  output logic               busy_o,
  output logic               drained_o,
  output logic               err_o,
  output logic [ADDR_W-1:0]  err_addr_o,
  input  logic               err_clr_i
);

  drain_state_e      state_r;
  logic              cyc_r;
  logic              stb_r;
  logic              we_r;
  logic [ADDR_W-1:0] adr_r;
  logic [DATA_W-1:0] dat_r;
  logic [SEL_W-1:0]  sel_r;
  logic              err_r;
  logic [ADDR_W-1:0] err_addr_r;

  logic              pop_s;
  logic              accept_s;
  logic              term_s;
  logic              err_hit_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [SEL_W-1:0]  rd_sel_s;
  logic [ADDR_W-1:0] rd_addr_s;

  // Pop/termination decode; the pop is gated by reset so no entry leaves the FIFO during reset.
  always_comb begin
    pop_s     = 1'b0;
    accept_s  = 1'b0;
    term_s    = 1'b0;
    err_hit_s = 1'b0;
    rd_data_s = fifo_rdata_i[ENTRY_W-1 -: DATA_W];
    rd_sel_s  = fifo_rdata_i[ADDR_W+SEL_W-1 -: SEL_W];
    rd_addr_s = fifo_rdata_i[ADDR_W-1:0];
    pop_s     = ~rst_i & (state_r == IDLE) & ~fifo_empty_i & ~hold_i;
    accept_s  = (state_r == REQ) & ~stall_i;
    term_s    = (accept_s | (state_r == WAIT)) & (ack_i | err_i);
    err_hit_s = term_s & err_i;
  end

  // Drain FSM and Wishbone request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cyc_r   <= 1'b0;
      stb_r   <= 1'b0;
      we_r    <= 1'b0;
      adr_r   <= '0;
      dat_r   <= '0;
      sel_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r <= FETCH;
          end
        end
        FETCH: begin
          adr_r   <= rd_addr_s;
          dat_r   <= rd_data_s;
          sel_r   <= rd_sel_s;
          cyc_r   <= 1'b1;
          stb_r   <= 1'b1;
          we_r    <= 1'b1;
          state_r <= REQ;
        end
        REQ: begin
          if (accept_s) begin
            stb_r <= 1'b0;
            we_r  <= 1'b0;
            // A response in the accept cycle closes the write without a WAIT cycle.
            if (term_s) begin
              cyc_r   <= 1'b0;
              state_r <= IDLE;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (term_s) begin
            cyc_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear and refreshes the address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_r      <= 1'b0;
      err_addr_r <= '0;
    end else if (err_hit_s) begin
      err_r <= 1'b1;
      if (~err_r | err_clr_i) begin
        err_addr_r <= adr_r;
      end
    end else if (err_clr_i) begin
      err_r <= 1'b0;
    end
  end

  assign fifo_re_o  = pop_s;
  assign cyc_o      = cyc_r;
  assign stb_o      = stb_r;
  assign we_o       = we_r;
  assign adr_o      = adr_r;
  assign dat_o      = dat_r;
  assign sel_o      = sel_r;
  assign busy_o     = (state_r != IDLE);
  assign drained_o  = fifo_empty_i & ~busy_o;
  assign err_o      = err_r;
  assign err_addr_o = err_addr_r;

endmodule

// File: tb/tb_wbuf_drain.sv
// Directed, table-driven bench for wbuf_drain with a small FIFO model feeding it.
module tb_wbuf_drain;
  import dcache_pkg::*;

  localparam int DW = 32;
  localparam int AW = 30;
  localparam int SW = 4;
  localparam int EW = DW + SW + AW;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i, fifo_empty_i, fifo_re_o, hold_i;
  logic          cyc_o, stb_o, we_o, stall_i, ack_i, err_i;
  logic          busy_o, drained_o, err_o, err_clr_i;
  logic [EW-1:0] fifo_rdata_i = '0;
  logic [AW-1:0] adr_o, err_addr_o;
  logic [DW-1:0] dat_o;
  logic [SW-1:0] sel_o;

  wbuf_drain dut (
    .clk_i(clk_i), .rst_i(rst_i), .fifo_empty_i(fifo_empty_i), .fifo_re_o(fifo_re_o),
    .fifo_rdata_i(fifo_rdata_i), .hold_i(hold_i), .cyc_o(cyc_o), .stb_o(stb_o),
    .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .stall_i(stall_i),
    .ack_i(ack_i), .err_i(err_i), .busy_o(busy_o), .drained_o(drained_o),
    .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
  );

  // FIFO model: entry k is the k-th pushed; index 0 is the all-zero reset image.
  wbuf_entry_t ents [0:15];
  int wr_ptr  = 1;
  int rd_ptr  = 1;
  int pop_cnt = 0;
  assign fifo_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk_i) begin
    if (fifo_re_o && rd_ptr != wr_ptr) begin
      fifo_rdata_i <= ents[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
      pop_cnt      <= pop_cnt + 1;
    end
  end

  // in  = {push, hold, stall, ack, err, clr, rst}
  // ex  = {fifo_re, cyc, stb, we, busy, drained, err_o}
  typedef struct {
    logic [6:0]    in;
    logic [6:0]    ex;
    int            ent;
    logic [AW-1:0] ea;
  } vec_t;
  vec_t vecs[$];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic wbuf_entry_t mk(logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    wbuf_entry_t e;
    e.address = a;
    e.data    = d;
    e.sel     = s;
    return e;
  endfunction

  function automatic void add(logic [6:0] in, logic [6:0] ex, int ent, logic [AW-1:0] ea);
    vec_t v;
    v.in  = in;
    v.ex  = ex;
    v.ent = ent;
    v.ea  = ea;
    vecs.push_back(v);
  endfunction

  logic          push_s;
  logic [6:0]    act;
  logic [EW-1:0] got_e;
  logic [AW-1:0] seen[$];
  int            pops0;
  bit            done;
  bit            ord_ok;

  initial begin
    ents[0]  = mk(30'h000, 32'h00000000, 4'h0);
    ents[1]  = mk(30'h100, 32'hDEADBEEF, 4'hF);
    ents[2]  = mk(30'h010, 32'h11111111, 4'h1);
    ents[3]  = mk(30'h011, 32'h22222222, 4'h3);
    ents[4]  = mk(30'h012, 32'h33333333, 4'hC);
    ents[5]  = mk(30'h040, 32'h44444444, 4'hF);
    ents[6]  = mk(30'h2A0, 32'hAAAA0000, 4'hF);
    ents[7]  = mk(30'h2A4, 32'hAAAA0004, 4'hF);
    ents[8]  = mk(30'h055, 32'h55555555, 4'h6);
    ents[9]  = mk(30'h077, 32'h77777777, 4'hF);
    ents[10] = mk(30'h078, 32'h78787878, 4'hF);
    ents[11] = mk(30'h099, 32'h99999999, 4'hF);
    ents[12] = mk(30'h0AB, 32'hABABABAB, 4'h9);
    ents[13] = mk(30'h0C0, 32'hC0C0C0C0, 4'hF);
    ents[14] = mk(30'h0C1, 32'hC1C1C1C1, 4'h5);
    ents[15] = mk(30'h000, 32'h00000000, 4'h0);

    // Reset state, then single store with ack one cycle after accept.
    add(7'b0000000, 7'b0000010,  0, 30'h000);
    add(7'b1000000, 7'b1000000, -1, 30'h000);
    add(7'b0000000, 7'b0000100, -1, 30'h000);
    add(7'b0000000, 7'b0111100,  1, 30'h000);
    add(7'b0001000, 7'b0100100,  1, 30'h000);
    add(7'b0000000, 7'b0000010,  1, 30'h000);
    // hold_i with three queued entries: no pop, bus idle.
    add(7'b1100000, 7'b0000000,  1, 30'h000);
    add(7'b1100000, 7'b0000000,  1, 30'h000);
    add(7'b1100000, 7'b0000000,  1, 30'h000);
    add(7'b0100000, 7'b0000000,  1, 30'h000);
    // Three writes, each stalled two cycles; ack/err in FETCH and stall in WAIT ignored.
    add(7'b0000000, 7'b1000000, -1, 30'h000);
    add(7'b0001100, 7'b0000100, -1, 30'h000);
    add(7'b0010000, 7'b0111100,  2, 30'h000);
    add(7'b0010000, 7'b0111100,  2, 30'h000);
    add(7'b0000000, 7'b0111100,  2, 30'h000);
    add(7'b0011000, 7'b0100100,  2, 30'h000);
    add(7'b0000000, 7'b1000000,  2, 30'h000);
    add(7'b0000000, 7'b0000100, -1, 30'h000);
    add(7'b0010000, 7'b0111100,  3, 30'h000);
    add(7'b0010000, 7'b0111100,  3, 30'h000);
    add(7'b0000000, 7'b0111100,  3, 30'h000);
    add(7'b0001000, 7'b0100100,  3, 30'h000);
    add(7'b0000000, 7'b1000000,  3, 30'h000);
    add(7'b0000000, 7'b0000100, -1, 30'h000);
    add(7'b0010000, 7'b0111100,  4, 30'h000);
    add(7'b1010000, 7'b0111100,  4, 30'h000);
    add(7'b0000000, 7'b0111100,  4, 30'h000);
    // hold_i raised in WAIT: write completes, next pop waits for hold_i=0.
    add(7'b0101000, 7'b0100100,  4, 30'h000);
    add(7'b0100000, 7'b0000000,  4, 30'h000);
    add(7'b0100000, 7'b0000000,  4, 30'h000);
    add(7'b0000000, 7'b1000000,  4, 30'h000);
    add(7'b0000000, 7'b0000100, -1, 30'h000);
    add(7'b0000000, 7'b0111100,  5, 30'h000);
    add(7'b0001000, 7'b0100100,  5, 30'h000);
    add(7'b0000000, 7'b0000010,  5, 30'h000);
    // Errors on 0x2A0 then 0x2A4: first address kept; then clear.
    add(7'b1000000, 7'b1000000,  5, 30'h000);
    add(7'b0000000, 7'b0000100, -1, 30'h000);
    add(7'b0000000, 7'b0111100,  6, 30'h000);
    add(7'b0000100, 7'b0100100,  6, 30'h000);
    add(7'b1000000, 7'b1000001,  6, 30'h2A0);
    add(7'b0000000, 7'b0000101, -1, 30'h2A0);
    add(7'b0000000, 7'b0111101,  7, 30'h2A0);
    add(7'b0000100, 7'b0100101,  7, 30'h2A0);
    add(7'b0000000, 7'b0000011,  7, 30'h2A0);
    add(7'b0000010, 7'b0000011,  7, 30'h2A0);
    add(7'b0000000, 7'b0000010,  7, 30'h2A0);
    // Ack in the accept cycle: cyc drops next cycle, no WAIT.
    add(7'b1000000, 7'b1000000,  7, 30'h2A0);
    add(7'b0000000, 7'b0000100, -1, 30'h2A0);
    add(7'b0001000, 7'b0111100,  8, 30'h2A0);
    add(7'b0000000, 7'b0000010,  8, 30'h2A0);
    // Error reloads address after clear; err+clear in the accept cycle: error wins.
    add(7'b1000000, 7'b1000000,  8, 30'h2A0);
    add(7'b0000000, 7'b0000100, -1, 30'h2A0);
    add(7'b0000000, 7'b0111100,  9, 30'h2A0);
    add(7'b0000100, 7'b0100100,  9, 30'h2A0);
    add(7'b1000000, 7'b1000001,  9, 30'h077);
    add(7'b0000000, 7'b0000101, -1, 30'h077);
    add(7'b0000110, 7'b0111101, 10, 30'h077);
    add(7'b0000000, 7'b0000011, 10, 30'h078);
    // Reset while stalled in REQ, FIFO non-empty: no pop during reset.
    add(7'b1000000, 7'b1000001, 10, 30'h078);
    add(7'b0000000, 7'b0000101, -1, 30'h078);
    add(7'b1010000, 7'b0111101, 11, 30'h078);
    add(7'b0010001, 7'b0111101, 11, 30'h078);
    add(7'b0000001, 7'b0000000,  0, 30'h000);
    add(7'b0000000, 7'b1000000,  0, 30'h000);
    add(7'b0000000, 7'b0000100, -1, 30'h000);
    add(7'b0000000, 7'b0111100, 12, 30'h000);
    add(7'b0001000, 7'b0100100, 12, 30'h000);
    add(7'b0000000, 7'b0000010, 12, 30'h000);

    rst_i = 1'b1; hold_i = 1'b0; stall_i = 1'b0; ack_i = 1'b0;
    err_i = 1'b0; err_clr_i = 1'b0; push_s = 1'b0;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      {push_s, hold_i, stall_i, ack_i, err_i, err_clr_i, rst_i} = vecs[i].in;
      if (push_s) wr_ptr = wr_ptr + 1;
      #1;
      act = {fifo_re_o, cyc_o, stb_o, we_o, busy_o, drained_o, err_o};
      n_chk++;
      if (act !== vecs[i].ex) begin
        n_fail++;
        $display("FAIL row%0d ctl {re,cyc,stb,we,busy,drained,err}: got %b want %b", i, act, vecs[i].ex);
      end
      if (vecs[i].ent >= 0) begin
        got_e = {dat_o, sel_o, adr_o};
        n_chk++;
        if (got_e !== ents[vecs[i].ent]) begin
          n_fail++;
          $display("FAIL row%0d bus {dat,sel,adr}: got %h want %h", i, got_e, ents[vecs[i].ent]);
        end
      end
      n_chk++;
      if (err_addr_o !== vecs[i].ea) begin
        n_fail++;
        $display("FAIL row%0d err_addr: got %h want %h", i, err_addr_o, vecs[i].ea);
      end
    end

    // Back-to-back pair with a responsive slave: two pops, program order, then drained.
    @(negedge clk_i);
    {hold_i, stall_i, ack_i, err_i, err_clr_i, rst_i} = 6'b000000;
    pops0  = pop_cnt;
    wr_ptr = wr_ptr + 2;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_i);
      ack_i = cyc_o & ~stb_o;
      if (stb_o) seen.push_back(adr_o);
      if (drained_o) done = 1'b1;
    end
    ack_i = 1'b0;
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL pair_drain: drained_o got %b want 1 within 40 cycles", drained_o);
    end
    n_chk++;
    if (pop_cnt - pops0 != 2) begin
      n_fail++;
      $display("FAIL pair_pops: got %0d want 2", pop_cnt - pops0);
    end
    ord_ok = (seen.size() == 2) && (seen[0] == 30'h0C0) && (seen[1] == 30'h0C1);
    n_chk++;
    if (!ord_ok) begin
      n_fail++;
      $display("FAIL pair_order: got %0d strobes want 2 at 0c0 then 0c1", seen.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
